// File: rtl/pulse_pkg.sv
// ============================================================================
// Module  : pulse_pkg
// Brief   : Shared widths and packed pulse-word layout for the pulse output path.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pulse_pkg;

    localparam int DEF_ENV_WORD_WIDTH = 24;
    localparam int DEF_PHASE_WIDTH    = 17;
    localparam int DEF_FREQ_WIDTH     = 9;
    localparam int DEF_AMP_WIDTH      = 16;
    localparam int DEF_CFG_WIDTH      = 4;

    localparam int PULSE_WORD_WIDTH = DEF_ENV_WORD_WIDTH + DEF_PHASE_WIDTH +
                                      DEF_FREQ_WIDTH + DEF_AMP_WIDTH + DEF_CFG_WIDTH;

    // Field order fixes the packing: env is the most significant field.
    typedef struct packed {
        logic [DEF_ENV_WORD_WIDTH-1:0] env;
        logic [DEF_PHASE_WIDTH-1:0]    phase;
        logic [DEF_FREQ_WIDTH-1:0]     freq;
        logic [DEF_AMP_WIDTH-1:0]      amp;
        logic [DEF_CFG_WIDTH-1:0]      cfg;
    } pulse_word_t;

endpackage

`default_nettype wire

// File: rtl/pulse_fifo_mem.sv
// ============================================================================
// Module  : pulse_fifo_mem
// Brief   : ENTRIES x WIDTH simple dual-port storage with wrapping pointers.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_fifo_mem
    import pulse_pkg::*;
#(
    parameter int ENTRIES = 7,
    parameter int WIDTH   = PULSE_WORD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o
);

    localparam int PTR_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(ENTRIES - 1);

    logic [WIDTH-1:0] mem_q [ENTRIES];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

    // Entry count need not be a power of two, so wrap explicitly.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en_i) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (rd_en_i) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];

endmodule

`default_nettype wire

// File: rtl/pulse_out_buf.sv
// ============================================================================
// Module  : pulse_out_buf
// Brief   : Pulse command FIFO with registered head and valid/ready output.
//           Optional drop counter enabled by PULSE_OUT_BUF_DROP_CNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_out_buf
    import pulse_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int ENV_WORD_WIDTH = DEF_ENV_WORD_WIDTH,
    parameter int PHASE_WIDTH    = DEF_PHASE_WIDTH,
    parameter int FREQ_WIDTH     = DEF_FREQ_WIDTH,
    parameter int AMP_WIDTH      = DEF_AMP_WIDTH,
    parameter int CFG_WIDTH      = DEF_CFG_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cstrobe_in,
    input  logic [ENV_WORD_WIDTH-1:0]  env_word_in,
    input  logic [PHASE_WIDTH-1:0]     phase_in,
    input  logic [FREQ_WIDTH-1:0]      freq_in,
    input  logic [AMP_WIDTH-1:0]       amp_in,
    input  logic [CFG_WIDTH-1:0]       cfg_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ENV_WORD_WIDTH-1:0]  env_word_out,
    output logic [PHASE_WIDTH-1:0]     phase_out,
    output logic [FREQ_WIDTH-1:0]      freq_out,
    output logic [AMP_WIDTH-1:0]       amp_out,
    output logic [CFG_WIDTH-1:0]       cfg_out,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    input  logic                       overflow_clr
`ifdef PULSE_OUT_BUF_DROP_CNT_EN
    ,
    output logic [15:0]                drop_count
`endif
);

    localparam int WORD_W  = ENV_WORD_WIDTH + PHASE_WIDTH + FREQ_WIDTH + AMP_WIDTH + CFG_WIDTH;
    localparam int ENTRIES = DEPTH - 1;
    localparam int LVL_W   = $clog2(DEPTH) + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [WORD_W-1:0] in_word;
    logic [WORD_W-1:0] mem_rd_data;
    logic [WORD_W-1:0] head_q, head_d;
    logic              valid_q, valid_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              ovf_q, ovf_d;

    logic full, mem_empty, pop, drop, accept, load, bypass, mem_wr, mem_rd;

    assign in_word = {env_word_in, phase_in, freq_in, amp_in, cfg_in};

    always_comb begin
        full      = (level_q == FULL_LVL);
        // Memory is empty when the whole occupancy sits in the output register.
        mem_empty = (level_q == {{(LVL_W-1){1'b0}}, valid_q});
        pop       = valid_q & out_ready;
        drop      = cstrobe_in & full & ~pop;
        accept    = cstrobe_in & ~drop;
        load      = ~valid_q | pop;
        bypass    = accept & load & mem_empty;
        mem_wr    = accept & ~bypass;
        mem_rd    = load & ~mem_empty;

        head_d  = head_q;
        valid_d = valid_q;
        if (load) begin
            if (!mem_empty) begin
                head_d  = mem_rd_data;
                valid_d = 1'b1;
            end else if (bypass) begin
                head_d  = in_word;
                valid_d = 1'b1;
            end else begin
                valid_d = 1'b0;
            end
        end

        level_d = level_q + LVL_W'(accept) - LVL_W'(pop);

        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (overflow_clr) begin
            ovf_d = 1'b0;
        end
    end

    pulse_fifo_mem #(
        .ENTRIES (ENTRIES),
        .WIDTH   (WORD_W)
    ) u_mem (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (mem_wr),
        .wr_data_i (in_word),
        .rd_en_i   (mem_rd),
        .rd_data_o (mem_rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            valid_q <= 1'b0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            valid_q <= valid_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef PULSE_OUT_BUF_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (overflow_clr) begin
            drop_cnt_d = drop ? 16'd1 : 16'd0;
        end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;
`endif

    assign out_valid = valid_q;
    assign {env_word_out, phase_out, freq_out, amp_out, cfg_out} = head_q;
    assign level     = level_q;
    assign overflow  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_pulse_out_buf.sv
// ============================================================================
// Module  : tb_pulse_out_buf
// Brief   : Directed and scoreboard checks for pulse_out_buf (DEPTH=8).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pulse_out_buf;
    import pulse_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cstrobe_in = 1'b0;
    logic [23:0] env_word_in = '0;
    logic [16:0] phase_in = '0;
    logic [8:0]  freq_in = '0;
    logic [15:0] amp_in = '0;
    logic [3:0]  cfg_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [23:0] env_word_out;
    logic [16:0] phase_out;
    logic [8:0]  freq_out;
    logic [15:0] amp_out;
    logic [3:0]  cfg_out;
    logic [3:0]  level;
    logic        overflow;
    logic        overflow_clr = 1'b0;
`ifdef PULSE_OUT_BUF_DROP_CNT_EN
    logic [15:0] drop_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pulse_out_buf #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .cstrobe_in   (cstrobe_in),
        .env_word_in  (env_word_in),
        .phase_in     (phase_in),
        .freq_in      (freq_in),
        .amp_in       (amp_in),
        .cfg_in       (cfg_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .env_word_out (env_word_out),
        .phase_out    (phase_out),
        .freq_out     (freq_out),
        .amp_out      (amp_out),
        .cfg_out      (cfg_out),
        .level        (level),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
`ifdef PULSE_OUT_BUF_DROP_CNT_EN
        ,
        .drop_count   (drop_count)
`endif
    );

    task automatic check_val(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic pulse_word_t head_word();
        pulse_word_t w;
        w = {env_word_out, phase_out, freq_out, amp_out, cfg_out};
        return w;
    endfunction

    pulse_word_t q[$];
    pulse_word_t w_in;
    logic        m_ovf;
    logic        m_pop, m_drop;
    int          strobes, drops, dut_pops;
    logic [15:0] m_dcnt;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_val("rst_valid", 72'(out_valid), 72'd0);
        check_val("rst_level", 72'(level), 72'd0);
        check_val("rst_ovf", 72'(overflow), 72'd0);
        check_val("rst_head", 72'(head_word()), 72'd0);
`ifdef PULSE_OUT_BUF_DROP_CNT_EN
        check_val("rst_dcnt", 72'(drop_count), 72'd0);
`endif
        tick();

        // Single strobe with ready high: one-cycle valid
        out_ready  = 1'b1;
        cstrobe_in = 1'b1;
        amp_in     = 16'h1234;
        tick();
        cstrobe_in = 1'b0;
        amp_in     = 16'h0;
        check_val("single_valid", 72'(out_valid), 72'd1);
        check_val("single_amp", 72'(amp_out), 72'h1234);
        check_val("single_level", 72'(level), 72'd1);
        tick();
        check_val("single_valid_off", 72'(out_valid), 72'd0);
        check_val("single_level_off", 72'(level), 72'd0);

        // Fill to full with ready low
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            cstrobe_in = 1'b1;
            freq_in    = 9'(i);
            tick();
        end
        check_val("fill_level", 72'(level), 72'd8);
        check_val("fill_ovf", 72'(overflow), 72'd0);
        freq_in = 9'd9;
        tick();
        cstrobe_in = 1'b0;
        check_val("drop_ovf", 72'(overflow), 72'd1);
        check_val("drop_level", 72'(level), 72'd8);
        check_val("drop_head", 72'(freq_out), 72'd1);
`ifdef PULSE_OUT_BUF_DROP_CNT_EN
        check_val("drop_dcnt", 72'(drop_count), 72'd1);
`endif
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        check_val("clr_ovf", 72'(overflow), 72'd0);
`ifdef PULSE_OUT_BUF_DROP_CNT_EN
        check_val("clr_dcnt", 72'(drop_count), 72'd0);
`endif
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check_val("drain_valid", 72'(out_valid), 72'd1);
            check_val("drain_freq", 72'(freq_out), 72'(i));
            tick();
        end
        check_val("drain_empty_valid", 72'(out_valid), 72'd0);
        check_val("drain_empty_level", 72'(level), 72'd0);

        // Full plus simultaneous push and pop
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            cstrobe_in = 1'b1;
            freq_in    = 9'(i);
            tick();
        end
        out_ready = 1'b1;
        freq_in   = 9'd9;
        tick();
        cstrobe_in = 1'b0;
        check_val("pp_level", 72'(level), 72'd8);
        check_val("pp_ovf", 72'(overflow), 72'd0);
        for (int i = 2; i <= 9; i++) begin
            check_val("pp_freq", 72'(freq_out), 72'(i));
            tick();
        end
        check_val("pp_empty_valid", 72'(out_valid), 72'd0);

        // Asynchronous reset mid-operation
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            cstrobe_in = 1'b1;
            freq_in    = 9'(20 + i);
            tick();
        end
        cstrobe_in = 1'b0;
        check_val("pre_rst_level", 72'(level), 72'd5);
        check_val("pre_rst_valid", 72'(out_valid), 72'd1);
        #1;
        reset = 1'b1;
        #1;
        check_val("async_rst_valid", 72'(out_valid), 72'd0);
        check_val("async_rst_level", 72'(level), 72'd0);
        cstrobe_in = 1'b1;
        freq_in    = 9'd30;
        @(posedge clk);
        @(negedge clk);
        reset      = 1'b0;
        cstrobe_in = 1'b0;
        #1;
        check_val("rst_strobe_ignored", 72'(level), 72'd0);
        @(negedge clk);
        cstrobe_in = 1'b1;
        freq_in    = 9'd31;
        amp_in     = 16'hBEEF;
        tick();
        cstrobe_in = 1'b0;
        check_val("post_rst_valid", 72'(out_valid), 72'd1);
        check_val("post_rst_freq", 72'(freq_out), 72'd31);
        out_ready = 1'b1;
        tick();
        check_val("post_rst_empty", 72'(level), 72'd0);

        // Random traffic against a scoreboard
        m_ovf    = 1'b0;
        m_dcnt   = 16'd0;
        strobes  = 0;
        drops    = 0;
        dut_pops = 0;
        for (int c = 0; c < 10000; c++) begin
            check_val("rnd_valid", 72'(out_valid), 72'(q.size() > 0));
            check_val("rnd_level", 72'(level), 72'(q.size()));
            check_val("rnd_ovf", 72'(overflow), 72'(m_ovf));
            if (q.size() > 0) begin
                check_val("rnd_head", 72'(head_word()), 72'(q[0]));
            end
`ifdef PULSE_OUT_BUF_DROP_CNT_EN
            check_val("rnd_dcnt", 72'(drop_count), 72'(m_dcnt));
`endif
            cstrobe_in   = ($urandom_range(0, 99) < 55);
            out_ready    = ($urandom_range(0, 99) < 45);
            overflow_clr = ($urandom_range(0, 31) == 0);
            env_word_in  = 24'($urandom);
            phase_in     = 17'($urandom);
            freq_in      = 9'($urandom);
            amp_in       = 16'($urandom);
            cfg_in       = 4'($urandom);
            w_in = '{env: env_word_in, phase: phase_in, freq: freq_in, amp: amp_in, cfg: cfg_in};

            m_pop  = (q.size() > 0) && out_ready;
            m_drop = cstrobe_in && (q.size() == DEPTH) && !m_pop;
            if (out_valid && out_ready) dut_pops++;
            if (cstrobe_in) strobes++;
            if (m_drop) drops++;
            if (m_pop) void'(q.pop_front());
            if (cstrobe_in && !m_drop) q.push_back(w_in);
            if (m_drop) m_ovf = 1'b1;
            else if (overflow_clr) m_ovf = 1'b0;
            if (overflow_clr) m_dcnt = m_drop ? 16'd1 : 16'd0;
            else if (m_drop && m_dcnt != 16'hFFFF) m_dcnt = m_dcnt + 16'd1;
            tick();
        end
        cstrobe_in   = 1'b0;
        overflow_clr = 1'b0;
        check_val("rnd_balance", 72'(strobes - drops), 72'(dut_pops + int'(level)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
